// File: rtl/commit_banner_serializer.sv
// Renders core_id (decimal), commit_id (hex) and dirty as a fixed 54-byte ASCII line; first byte valid 34 cycles after start, each byte held until out_ready.
// Define COMMIT_BANNER_AUTOSTART_EN to also emit one banner automatically after every reset release.
module commit_banner_serializer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] core_id,
  input  logic [39:0] commit_id,
  input  logic        dirty,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_LOAD    = 2'd2;
  localparam logic [1:0] S_EMIT    = 2'd3;

  localparam logic [39:0]  STR_CORE  = "Core ";
  localparam logic [143:0] STR_MID   = "'s Commit SHA is: ";
  localparam logic [71:0]  STR_DIRTY = ", dirty: ";

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic [39:0] commit_q, commit_d;
  logic        dirty_q, dirty_d;
  logic [5:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;

  logic        start_eff;
  logic        accept;
  logic [38:0] bcd_adj;
  logic [9:0]  blank;
  logic [79:0] dec_chars;
  logic [79:0] hex_chars;
  logic [431:0] line;
  logic [5:0]  byte_sel;
  logic [8:0]  bit_off;
  logic [7:0]  line_byte;

`ifdef COMMIT_BANNER_AUTOSTART_EN
  logic auto_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      auto_q <= 1'b1;
    end else begin
      auto_q <= 1'b0;
    end
  end

  assign start_eff = start | auto_q;
`else
  assign start_eff = start;
`endif

  // A start landing on the done cycle must not chain a second banner.
  assign accept = start_eff && (state_q == S_IDLE) && !done_q;

  // Double-dabble add-3; the top digit never reaches 5 before a shift for 32-bit input.
  always_comb begin
    bcd_adj = bcd_q[38:0];
    for (int i = 0; i < 9; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero digits print as spaces; the units digit is always shown.
  always_comb begin
    blank    = '0;
    blank[9] = (bcd_q[39:36] == 4'd0);
    for (int i = 8; i >= 1; i--) begin
      blank[i] = blank[i+1] && (bcd_q[4*i +: 4] == 4'd0);
    end
    blank[0] = 1'b0;
  end

  always_comb begin
    dec_chars = '0;
    hex_chars = '0;
    for (int i = 0; i < 10; i++) begin
      dec_chars[8*i +: 8] = blank[i] ? 8'h20 : {4'h3, bcd_q[4*i +: 4]};
      hex_chars[8*i +: 8] = (commit_q[4*i +: 4] < 4'd10) ? {4'h3, commit_q[4*i +: 4]}
                                                          : 8'h57 + {4'h0, commit_q[4*i +: 4]};
    end
  end

  assign line = {STR_CORE, dec_chars, STR_MID, hex_chars, STR_DIRTY, 7'h18, dirty_q, 8'h0A};

  always_comb begin
    byte_sel = 6'd0;
    if ((state_q == S_EMIT) && (idx_q != 6'd53)) begin
      byte_sel = idx_q + 6'd1;
    end
  end

  assign bit_off   = {6'd53 - byte_sel, 3'b000};
  assign line_byte = line[bit_off +: 8];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    commit_d = commit_q;
    dirty_d  = dirty_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_CONVERT;
          busy_d   = 1'b1;
          cnt_d    = 5'd0;
          bin_d    = core_id;
          bcd_d    = '0;
          commit_d = commit_id;
          dirty_d  = dirty;
        end
      end
      S_CONVERT: begin
        bcd_d = {bcd_adj, bin_q[31]};
        bin_d = {bin_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        idx_d   = 6'd0;
        data_d  = line_byte;
        valid_d = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (valid_q && out_ready) begin
          if (idx_q == 6'd53) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d  = idx_q + 6'd1;
            data_d = line_byte;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      bin_q    <= '0;
      bcd_q    <= '0;
      commit_q <= '0;
      dirty_q  <= 1'b0;
      idx_q    <= 6'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      commit_q <= commit_d;
      dirty_q  <= dirty_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_commit_banner_serializer.sv
// Directed bench for commit_banner_serializer: expected lines are hand-written ASCII strings.
module tb_commit_banner_serializer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] core_id;
  logic [39:0] commit_id;
  logic        dirty;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  localparam string L1 = "Core          0's Commit SHA is: 68b04f5767, dirty: 0\n";
  localparam string L2 = "Core 4294967295's Commit SHA is: 0000000000, dirty: 1\n";
  localparam string L3 = "Core          7's Commit SHA is: abcdef0123, dirty: 0\n";
  localparam string L6 = "Core    1234567's Commit SHA is: 00fedcba98, dirty: 1\n";

  always #5 clock = ~clock;

  commit_banner_serializer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .core_id   (core_id),
    .commit_id (commit_id),
    .dirty     (dirty),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge where start (or reset release) has just been driven.
  task automatic run_banner(input string tag, input string exp, input int rdy_pct,
                            input bit do_start, input bit extra);
    logic [7:0] got[$];
    logic [7:0] prev_d;
    logic [7:0] eb;
    logic [63:0] obs;
    bit prev_stall;
    bit seen_done;
    bit r;
    int stall_err;
    int done_k;
    got.delete();
    prev_d = 8'h00;
    prev_stall = 1'b0;
    seen_done = 1'b0;
    stall_err = 0;
    done_k = 0;
    if (do_start) start = 1'b1;
    for (int k = 1; k <= 800 && !seen_done; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (extra && (k == 5 || k == 40)) start = 1'b1;
      if (k == 1) begin
        check({tag, "_busy_e0"}, busy, 1);
        core_id   = ~core_id;
        commit_id = ~commit_id;
        dirty     = ~dirty;
      end
      if (k == 33) check({tag, "_valid_e32"}, out_valid, 0);
      if (k == 34) begin
        check({tag, "_valid_e33"}, out_valid, 1);
        check({tag, "_first_byte"}, out_data, 8'h43);
      end
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_d)) stall_err++;
      if (done === 1'b1) begin
        seen_done = 1'b1;
        done_k = k;
        check({tag, "_busy_at_done"}, busy, 0);
        if (extra) start = 1'b1;
      end else begin
        r = ($urandom_range(99) < rdy_pct);
        out_ready = r;
        if (out_valid && r) got.push_back(out_data);
        prev_stall = out_valid && !r;
        prev_d = out_data;
      end
    end
    check({tag, "_done_seen"}, seen_done, 1);
    if (rdy_pct == 100) check({tag, "_done_cycle"}, done_k, 88);
    check({tag, "_byte_count"}, got.size(), 54);
    for (int i = 0; i < 54; i++) begin
      eb = exp[i];
      obs = (i < got.size()) ? {56'd0, got[i]} : 64'hDEAD;
      check($sformatf("%s_byte%0d", tag, i), obs, {56'd0, eb});
    end
    check({tag, "_stall_stable"}, stall_err, 0);
    @(negedge clock);
    start = 1'b0;
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_no_start_on_done"}, busy, 0);
    repeat (3) @(negedge clock);
    check({tag, "_idle_after"}, out_valid, 0);
  endtask

  initial begin
    int stray;
    logic [7:0] eb;
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    core_id = 32'd0;
    commit_id = 40'd0;
    dirty = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 8'h00);

`ifdef COMMIT_BANNER_AUTOSTART_EN
    core_id = 32'd0; commit_id = 40'h68b04f5767; dirty = 1'b0;
    reset = 1'b0;
    run_banner("auto1", L1, 100, 1'b0, 1'b0);
    @(negedge clock);
    core_id = 32'd7; commit_id = 40'habcdef0123; dirty = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    run_banner("auto2", L3, 100, 1'b0, 1'b0);
    stray = 0;
    repeat (150) begin
      @(negedge clock);
      if (out_valid === 1'b1 || done === 1'b1) stray++;
    end
    check("auto_single", stray, 0);
`else
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("no_start_idle", busy, 0);

    @(negedge clock);
    core_id = 32'd0; commit_id = 40'h68b04f5767; dirty = 1'b0;
    run_banner("t1", L1, 100, 1'b1, 1'b0);

    @(negedge clock);
    core_id = 32'd4294967295; commit_id = 40'd0; dirty = 1'b1;
    run_banner("t2", L2, 100, 1'b1, 1'b0);

    @(negedge clock);
    core_id = 32'd7; commit_id = 40'habcdef0123; dirty = 1'b0;
    run_banner("t3", L3, 30, 1'b1, 1'b0);

    @(negedge clock);
    core_id = 32'd0; commit_id = 40'h68b04f5767; dirty = 1'b0;
    run_banner("t4", L1, 100, 1'b1, 1'b1);

    // Abort mid-line: byte 20 is on the bus 54 negedges after start.
    @(negedge clock);
    core_id = 32'd0; commit_id = 40'h68b04f5767; dirty = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 54; k++) begin
      @(negedge clock);
      start = 1'b0;
    end
    eb = L1[20];
    check("t5_valid_idx20", out_valid, 1);
    check("t5_byte_idx20", out_data, eb);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_data", out_data, 8'h00);
    stray = 0;
    repeat (100) begin
      @(negedge clock);
      if (out_valid === 1'b1 || done === 1'b1) stray++;
    end
    check("t5_abandoned", stray, 0);

    @(negedge clock);
    core_id = 32'd1234567; commit_id = 40'h00fedcba98; dirty = 1'b1;
    run_banner("t6", L6, 100, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
